// File: rtl/clockgate_ctrl_pkg.sv
// Shared types and helpers for the clockgate_ctrl gated-clock controller.
// Optional OFF-cycle statistics are enabled with CLOCKGATE_CTRL_STATS_EN.
package clockgate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_WAKE = 2'b01,
    ST_ON   = 2'b10,
    ST_IDLE = 2'b11
  } cg_state_e;

  localparam int unsigned STAT_W = 32;

  // Ceiling log2, minimum 0; used for counter sizing at elaboration.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v != 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clockgate_ctrl_ch.sv
// One gated-clock channel: wake/idle FSM, hysteresis counter, enable latch and AND.
// CLOCKGATE_CTRL_STATS_EN adds a saturating count of cycles spent in OFF.
module clockgate_ctrl_ch
  import clockgate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate_force_i,
  input  logic              req_i,
`ifdef CLOCKGATE_CTRL_STATS_EN
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_off_cnt_o,
`endif
  output logic              eclk_o,
  output logic              ready_o,
  output logic              gated_o
);

  localparam int unsigned CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned CW      = clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  cg_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          gated_q, gated_d;
  logic          gen_c;
  logic          gen_lat;

  // Next-state, counter and registered status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (req_i) begin
          if (WAKE_CYCLES != 0) begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_WAKE: begin
        if (cnt_q <= CNT_ONE) state_d = ST_ON;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      ST_ON: begin
        if (!req_i) begin
          state_d = ST_IDLE;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_IDLE: begin
        if (req_i)                 state_d = ST_ON;
        else if (cnt_q <= CNT_ONE) state_d = ST_OFF;
        else                       cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_ON) || (state_d == ST_IDLE);
    gated_d = (state_d == ST_OFF);
  end

  // Reset parks the channel in IDLE so downstream logic sees a running clock
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= IDLE_LOAD;
      ready_q <= 1'b0;
      gated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      gated_q <= gated_d;
    end
  end

  // Enable is latched while clk is low so every eclk high phase is full width
  assign gen_c = (state_q != ST_OFF) | gate_force_i;

  always_latch begin
    if (!clk) gen_lat = gen_c;
  end

  assign eclk_o  = clk & gen_lat;
  assign ready_o = ready_q;
  assign gated_o = gated_q;

`ifdef CLOCKGATE_CTRL_STATS_EN
  logic [STAT_W-1:0] off_cnt_q, off_cnt_d;

  // Clear wins over increment; count holds at all-ones
  always_comb begin
    off_cnt_d = off_cnt_q;
    if (stat_clr_i)
      off_cnt_d = '0;
    else if ((state_q == ST_OFF) && (off_cnt_q != {STAT_W{1'b1}}))
      off_cnt_d = off_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) off_cnt_q <= '0;
    else       off_cnt_q <= off_cnt_d;
  end

  assign stat_off_cnt_o = off_cnt_q;
`endif

endmodule

// File: rtl/clockgate_ctrl.sv
// Multi-channel self-timed clock gating controller; fans te/reset out to N channels.
// Define CLOCKGATE_CTRL_STATS_EN for per-channel OFF-cycle statistics.
module clockgate_ctrl
  import clockgate_ctrl_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  te,
  input  logic [N-1:0]          en,
  input  logic [N-1:0]          force_on,
`ifdef CLOCKGATE_CTRL_STATS_EN
  input  logic                  stat_clr,
  output logic [N*STAT_W-1:0]   stat_off_cnt,
`endif
  output logic [N-1:0]          eclk,
  output logic [N-1:0]          ready,
  output logic [N-1:0]          gated
);

  logic gate_force;

  // Test mode and reset both hold every gate open
  assign gate_force = te | reset;

  for (genvar g = 0; g < N; g++) begin : g_ch
    clockgate_ctrl_ch #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .gate_force_i   (gate_force),
      .req_i          (en[g] | force_on[g]),
`ifdef CLOCKGATE_CTRL_STATS_EN
      .stat_clr_i     (stat_clr),
      .stat_off_cnt_o (stat_off_cnt[g*STAT_W +: STAT_W]),
`endif
      .eclk_o         (eclk[g]),
      .ready_o        (ready[g]),
      .gated_o        (gated[g])
    );
  end

endmodule

// File: doc/clockgate_ctrl.md
Name: clockgate_ctrl

Overview:
- Multi-channel, self-timed clock gating controller for per-block clock domains hanging off one root clock.
- Each channel wakes its gated clock on activity, runs for a programmable warm-up, and holds the clock for an idle hysteresis window.
- Each channel gates its clock off again once that window expires with no activity.
- Sits between block activity/request logic and the gated-clock loads; the glitch-free latch-and-AND gating cell is inside each channel.

Parameters:
- N, 4: number of independent gated-clock channels (1..32).
- IDLE_CYCLES, 16: cycles the clock keeps running after the last sampled activity (>=1).
- WAKE_CYCLES, 2: warm-up cycles after wake before ready asserts (>=0).
- CW, derived: counter width, clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1); not user-overridable.

Ports:
- clk  in  1  root clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- te  in  1  test enable; forces all gate enables on, FSMs unaffected.
- en  in  N  per-channel activity request, sampled on rising clk.
- force_on  in  N  per-channel software override; treated as en=1 for the FSM.
- eclk  out  N  gated clocks.
- ready  out  N  registered; channel clock stable and usable.
- gated  out  N  registered; channel in OFF (clock stopped).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state changes on rising clk.
- Per-channel request: req = en[i] | force_on[i].
- Gate enable: gen = (state != OFF) | te | reset.
  - Captured by a latch transparent while clk low.
  - eclk[i] = clk & latched gen. No truncated or glitched high phases.
- States, with cnt a CW-bit down counter:
  - OFF: gen=0.
    - req=1 and WAKE_CYCLES>0 -> WAKE, cnt=WAKE_CYCLES.
    - req=1 and WAKE_CYCLES=0 -> ON.
  - WAKE: gen=1, ready=0. cnt decrements each cycle; at cnt==1 -> ON. WAKE lasts exactly WAKE_CYCLES cycles.
    - req dropping during WAKE does not abort; the channel reaches ON, then IDLE.
  - ON: gen=1.
    - req=0 -> IDLE, cnt=IDLE_CYCLES.
  - IDLE: gen=1.
    - req=1 -> ON.
    - Otherwise cnt decrements; at cnt==1 with req=0 -> OFF.
    - The clock therefore runs exactly IDLE_CYCLES cycles after the last cycle in which req was sampled 1.
- Outputs:
  - ready = registered (next_state in {ON, IDLE}).
  - gated = registered (next_state == OFF).
- Wake latency: req sampled at edge t in OFF.
  - First eclk high phase at cycle t+1.
  - ready=1 from t+1+WAKE_CYCLES.
- Reset (synchronous):
  - All channels go to IDLE, cnt=IDLE_CYCLES, ready=0, gated=0.
  - gen forced 1 while reset is high so downstream synchronous resets see clock edges.
  - ready=1 from the first cycle after reset deasserts.
  - With no request, channels gate off IDLE_CYCLES cycles after reset release.
  - Reset mid-WAKE/IDLE/OFF takes the same path; no residual count.
- te: affects gen only. FSM, ready and gated keep tracking req, so leaving test mode gates cleanly.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
- Macro CLOCKGATE_CTRL_STATS_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_off_cnt (N*32).
  - Per channel, a 32-bit saturating count of cycles spent in OFF.
  - stat_clr zeroes all counters on the next edge and has priority over increment.
  - Reset clears the counters.
  - Saturates at 0xFFFFFFFF.
- Not defined: ports and logic are absent; all behaviour above is unchanged.

Decomposition:
- Package clockgate_ctrl_pkg:
  - State enum (OFF=2'b00, WAKE=2'b01, ON=2'b10, IDLE=2'b11).
  - Function clog2.
  - Localparam STAT_W=32.
- Sub-module clockgate_ctrl_ch: one channel (FSM, counter, optional stat counter, enable latch, AND).
- Top module: generate loop over N channels plus te/reset fan-out.

Test Plan:
- Reset then idle: N=4, IDLE_CYCLES=16, en=0, deassert reset at cycle 0 -> ready=1 cycles 1..16; all gated=1 and eclk flat from cycle 17.
- Wake latency: channel 0 OFF, en[0]=1 at edge t, WAKE_CYCLES=2 -> eclk[0] pulses from t+1; ready[0]=1 at t+3; other channels stay gated.
- Hysteresis re-arm: channel ON, en pulses 0 for 10 cycles then 1 -> stays IDLE->ON, never gated; en then 0 -> gated exactly 16 cycles after last en=1.
- Abort-free wake: en=1 for one cycle in OFF -> WAKE 2 cycles, ON 1 cycle, IDLE 16, then OFF.
- Test enable: all channels OFF, te=1 -> every eclk toggles every cycle, gated stays 1; te=0 -> eclk stops within one clk low phase with no glitch pulse.
- Stats (macro on): channel OFF for 100 cycles -> stat_off_cnt[31:0]=100; stat_clr at cycle 50 with OFF continuing -> count restarts from 0; preset to 0xFFFFFFFE and run 5 OFF cycles -> holds 0xFFFFFFFF.
